// File: rtl/rgb_line_buffer_feeder.sv
// rgb_line_buffer_feeder: buffers two rows per RGB channel and streams 3-pixel vertical columns
module rgb_line_buffer_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    pix_sof,
  input  logic [DATA_WIDTH-1:0]   pix_r,
  input  logic [DATA_WIDTH-1:0]   pix_g,
  input  logic [DATA_WIDTH-1:0]   pix_b,
  output logic [3*DATA_WIDTH-1:0] col_r,
  output logic [3*DATA_WIDTH-1:0] col_g,
  output logic [3*DATA_WIDTH-1:0] col_b,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic                    col_last,
  output logic                    frame_done,
  output logic                    sof_err
);
  localparam int DW = DATA_WIDTH;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic [XW-1:0] x_q, x_d, x_px;
  logic [YW-1:0] y_q, y_d, y_px;
  logic in_frame_q, in_frame_d, frame_done_q, frame_done_d, sof_err_q, sof_err_d;
  logic col_valid_q, col_last_q;
  logic [3*DW-1:0] col_r_q, col_g_q, col_b_q;
  logic accept, proc, load, x_end, y_end;
  // Each line-buffer word packs {b, g, r} so one access serves all three channels
  logic [3*DW-1:0] lb0 [IMG_WIDTH];
  logic [3*DW-1:0] lb1 [IMG_WIDTH];
  logic [3*DW-1:0] top, mid;
  assign pix_ready = !rst && (!col_valid_q || col_ready);
  always_comb begin
    accept       = pix_valid && pix_ready;
    proc         = accept && (pix_sof || in_frame_q);
    x_px         = pix_sof ? '0 : x_q;
    y_px         = pix_sof ? '0 : y_q;
    x_end        = x_px == XW'(IMG_WIDTH - 1);
    y_end        = y_px == YW'(IMG_HEIGHT - 1);
    load         = proc && (y_px >= YW'(2));
    x_d          = !proc ? x_q : x_end ? '0 : x_px + 1'b1;
    y_d          = !proc ? y_q : !x_end ? y_px : y_end ? '0 : y_px + 1'b1;
    in_frame_d   = !proc ? in_frame_q : !(x_end && y_end);
    frame_done_d = proc && x_end && y_end;
    sof_err_d    = accept && (pix_sof ? in_frame_q && (x_q != '0 || y_q != '0) : !in_frame_q);
    top          = lb1[x_px];
    mid          = lb0[x_px];
  end
  // Buffer RAM is never reset: stale rows are masked by the y >= 2 gate
  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[x_px] <= lb0[x_px];
      lb0[x_px] <= {pix_b, pix_g, pix_r};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      col_valid_q  <= 1'b0;
      col_last_q   <= 1'b0;
      col_r_q      <= '0;
      col_g_q      <= '0;
      col_b_q      <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      if (!col_valid_q || col_ready) begin
        col_valid_q <= load;
        col_last_q  <= load && x_end;
      end
      if (load) begin
        col_r_q <= {pix_r, mid[DW-1:0],      top[DW-1:0]};
        col_g_q <= {pix_g, mid[2*DW-1:DW],   top[2*DW-1:DW]};
        col_b_q <= {pix_b, mid[3*DW-1:2*DW], top[3*DW-1:2*DW]};
      end
    end
  end
  assign col_r      = col_r_q;
  assign col_g      = col_g_q;
  assign col_b      = col_b_q;
  assign col_valid  = col_valid_q;
  assign col_last   = col_last_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
endmodule
